// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner
//   Latches four BCD digits into a shadow register on a load strobe and scans
//   them onto a common-segment 4-digit 7-segment display. Each digit gets one
//   refresh slot of REFRESH_DIV cycles. All anodes are held off for the first
//   BLANK_CYC cycles of each slot to suppress ghosting. Leading zeros can
//   optionally be blanked.
//
//   Optional feature macro: DISP_DP_EN. When it is defined, the block adds a
//   per-digit decimal-point mask input and a dp output.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset (highest priority)
//   ones..thousands  BCD digit inputs, sampled only when load=1
//   load         single-cycle capture strobe for the shadow register
//   blank_lz     1 = blank leading zeros
//   dp_mask      (DISP_DP_EN) per-digit decimal-point enable, captured on load
//   seg          segments {g,f,e,d,c,b,a}, registered, polarity SEG_ACTIVE_LOW
//   dp           (DISP_DP_EN) decimal point, registered, polarity SEG_ACTIVE_LOW
//   an           digit anodes (an[0]=ones), registered, polarity AN_ACTIVE_LOW
//   digit_sel    slot currently being scanned
//   frame_done   one-cycle pulse on the slot 3 -> 0 wrap
module bcd_display_scanner #(
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYC      = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic [3:0] thousands,
  input  logic       load,
  input  logic       blank_lz,
`ifdef DISP_DP_EN
  input  logic [3:0] dp_mask,
  output logic       dp,
`endif
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [1:0] digit_sel,
  output logic       frame_done
);

  localparam int            PW  = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] TC  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLK = PW'(BLANK_CYC);

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'h3F;
      4'd1:    dec7 = 7'h06;
      4'd2:    dec7 = 7'h5B;
      4'd3:    dec7 = 7'h4F;
      4'd4:    dec7 = 7'h66;
      4'd5:    dec7 = 7'h6D;
      4'd6:    dec7 = 7'h7D;
      4'd7:    dec7 = 7'h07;
      4'd8:    dec7 = 7'h7F;
      4'd9:    dec7 = 7'h6F;
      default: dec7 = 7'h79;  // non-BCD shows "E"
    endcase
  endfunction

  logic [PW-1:0]   cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic            fd_q, fd_d;
  logic [3:0][3:0] shd_q, shd_d;  // [0]=ones .. [3]=thousands
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic            tc, guard, act;
  logic [3:0]      lzb;           // per-digit leading-zero blank
`ifdef DISP_DP_EN
  logic [3:0]      dpm_q, dpm_d;
  logic            dp_q, dp_d;
`endif

  always_comb begin
    tc    = (cnt_q == TC);
    cnt_d = tc ? '0 : cnt_q + 1'b1;
    sel_d = tc ? sel_q + 2'd1 : sel_q;
    fd_d  = tc && (sel_q == 2'd3);
    shd_d = load ? {thousands, hundreds, tens, ones} : shd_q;
`ifdef DISP_DP_EN
    dpm_d = load ? dp_mask : dpm_q;
`endif

    // A digit is blanked only if it and every digit above it is zero. Invalid
    // codes are nonzero, so they break the chain. Ones is never blanked.
    lzb    = 4'b0000;
    lzb[3] = blank_lz && (shd_q[3] == 4'd0);
    for (int k = 2; k >= 1; k--)
      lzb[k] = lzb[k+1] && (shd_q[k] == 4'd0);

    guard = (cnt_q < BLK);
    act   = !guard && !lzb[sel_q];

    seg_d = (act ? dec7(shd_q[sel_q]) : 7'h00) ^ {7{SEG_ACTIVE_LOW}};
    an_d  = (act ? (4'b0001 << sel_q) : 4'b0000) ^ {4{AN_ACTIVE_LOW}};
`ifdef DISP_DP_EN
    dp_d  = (!guard && dpm_q[sel_q]) ^ SEG_ACTIVE_LOW;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sel_q <= 2'd0;
      fd_q  <= 1'b0;
      shd_q <= '0;
      seg_q <= {7{SEG_ACTIVE_LOW}};
      an_q  <= {4{AN_ACTIVE_LOW}};
`ifdef DISP_DP_EN
      dpm_q <= 4'b0000;
      dp_q  <= SEG_ACTIVE_LOW;
`endif
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      fd_q  <= fd_d;
      shd_q <= shd_d;
      seg_q <= seg_d;
      an_q  <= an_d;
`ifdef DISP_DP_EN
      dpm_q <= dpm_d;
      dp_q  <= dp_d;
`endif
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign digit_sel  = sel_q;
  assign frame_done = fd_q;
`ifdef DISP_DP_EN
  assign dp         = dp_q;
`endif

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner at REFRESH_DIV=4, BLANK_CYC=1,
// active-low segments and anodes. ph counts clock edges since the last reset
// edge; after edge ph the registered outputs reflect the state at ph-1, where
// the state at ph has prescaler ph%4 and slot (ph/4)%4.
module tb_bcd_display_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] ones = 0, tens = 0, hundreds = 0, thousands = 0;
  logic       load = 1'b0, blank_lz = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic [1:0] digit_sel;
  logic       frame_done;
`ifdef DISP_DP_EN
  logic [3:0] dp_mask = 4'b0000;
  logic       dp;
`endif

  int n_chk = 0, n_fail = 0;
  int ph = 0;

  bcd_display_scanner #(
    .REFRESH_DIV(4), .BLANK_CYC(1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
    .load(load), .blank_lz(blank_lz),
`ifdef DISP_DP_EN
    .dp_mask(dp_mask), .dp(dp),
`endif
    .seg(seg), .an(an), .digit_sel(digit_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @ph=%0d: got %0h expected %0h", tag, ph, got, exp);
    end
  endtask

  function automatic logic [6:0] inv(input logic [6:0] x);
    return ~x;
  endfunction

  task automatic step();
    @(posedge clk); #1;
    ph++;
  endtask

  task automatic load_digits(input logic [3:0] th, hu, te, on);
    thousands = th; hundreds = hu; tens = te; ones = on;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Advance until the outputs show the guard cycle of the given slot.
  task automatic goto_out(input int slot);
    int n = 0;
    do begin
      step();
      n++;
    end while (((ph - 1) % 16 != slot * 4) && n < 20);
    if ((ph - 1) % 16 != slot * 4) begin
      n_chk++; n_fail++;
      $display("FAIL goto_slot%0d: slot start not reached in %0d cycles", slot, n);
    end
  endtask

  task automatic chk_slot(input int slot, input logic [3:0] an_exp,
                          input logic [6:0] seg_exp, input bit do_seg);
    goto_out(slot);
    chk($sformatf("an_guard%0d", slot), an, 4'hF);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("an_slot%0d", slot), an, an_exp);
      if (do_seg) chk($sformatf("seg_slot%0d", slot), seg, seg_exp);
    end
  endtask

  logic [3:0] an_tab [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] t4_seg [4];

  initial begin
    // 1. reset values, then free-running scan timing
    repeat (3) step();
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_sel", digit_sel, 0);
    chk("rst_fd", frame_done, 0);
`ifdef DISP_DP_EN
    chk("rst_dp", dp, 1);
`endif
    reset = 1'b0;
    ph = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      chk("scan_sel", digit_sel, (ph / 4) % 4);
      chk("scan_fd", frame_done, (ph % 16) == 0);
    end

    // 2. normal display 1234
    load_digits(4'd1, 4'd2, 4'd3, 4'd4);
    chk_slot(0, 4'hE, inv(7'h66), 1);
    chk_slot(1, 4'hD, inv(7'h4F), 1);
    chk_slot(2, 4'hB, inv(7'h5B), 1);
    chk_slot(3, 4'h7, inv(7'h06), 1);

    // 3. leading-zero blanking on 0007
    blank_lz = 1'b1;
    load_digits(4'd0, 4'd0, 4'd0, 4'd7);
    chk_slot(0, 4'hE, inv(7'h07), 1);
    chk_slot(1, 4'hF, 7'h00, 0);
    chk_slot(2, 4'hF, 7'h00, 0);
    chk_slot(3, 4'hF, 7'h00, 0);
    blank_lz = 1'b0;
    chk_slot(1, 4'hD, inv(7'h3F), 1);
    chk_slot(2, 4'hB, inv(7'h3F), 1);
    chk_slot(3, 4'h7, inv(7'h3F), 1);

    // 4. invalid digit, then inputs ignored without load
    load_digits(4'd1, 4'hC, 4'd3, 4'd4);
    chk_slot(2, 4'hB, inv(7'h79), 1);
    thousands = 4'd8; hundreds = 4'd8; tens = 4'd8; ones = 4'd8;
    t4_seg = '{inv(7'h66), inv(7'h4F), inv(7'h79), inv(7'h06)};
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 4; k++)
        chk_slot(k, an_tab[k], t4_seg[k], 1);

    // 5a. load 9999 on the slot-1 terminal-count edge
    while (ph % 16 != 7) step();
    load_digits(4'd9, 4'd9, 4'd9, 4'd9);
    chk("bnd_old_an", an, 4'hD);
    chk("bnd_old_seg", seg, inv(7'h4F));
    step();
    chk("bnd_guard_an", an, 4'hF);
    step();
    chk("bnd_new_an", an, 4'hB);
    chk("bnd_new_seg", seg, inv(7'h6F));

    // 5b. reset mid-slot 2
    reset = 1'b1;
    step();
    chk("mrst_an", an, 4'hF);
    chk("mrst_seg", seg, 7'h7F);
    chk("mrst_sel", digit_sel, 0);
    chk("mrst_fd", frame_done, 0);
    step();
    chk("mrst_fd2", frame_done, 0);
    reset = 1'b0;
    ph = 0;
    chk_slot(0, 4'hE, inv(7'h3F), 1);
    chk_slot(3, 4'h7, inv(7'h3F), 1);

`ifdef DISP_DP_EN
    // 6. decimal point on slot 2 only
    dp_mask = 4'b0100;
    load_digits(4'd1, 4'd2, 4'd3, 4'd4);
    dp_mask = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      chk("dp", dp, !((((ph - 1) % 4) != 0) && ((((ph - 1) / 4) % 4) == 2)));
      step();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Downstream consumer of the four-digit BCD counter.
- Latches the four BCD digits (ones/tens/hundreds/thousands) into a shadow register on a load strobe.
- Time-multiplexes the digits onto a common-segment 4-digit 7-segment display, one digit per refresh slot, with an anode-off guard interval and optional leading-zero blanking.
- Sits between the counter and the board display pins.

Parameters:
- REFRESH_DIV, 50000, clock cycles per digit slot; legal range ≥2.
- BLANK_CYC, 16, guard cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- SEG_ACTIVE_LOW, 1, 1 inverts seg (and dp) at the output register.
- AN_ACTIVE_LOW, 1, 1 inverts an at the output register.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ones  in  4  BCD ones digit
- tens  in  4  BCD tens digit
- hundreds  in  4  BCD hundreds digit
- thousands  in  4  BCD thousands digit
- load  in  1  single-cycle strobe; captures the four digits into the shadow register
- blank_lz  in  1  1 = blank leading zeros
- seg  out  7  segments {g,f,e,d,c,b,a}
- an  out  4  digit anodes; an[0] = ones, an[3] = thousands
- digit_sel  out  2  index of the slot currently being scanned
- frame_done  out  1  one-cycle pulse when the scan wraps from slot 3 to slot 0

Behaviour:
- Clock and reset: single clock clk. reset is synchronous, active-high, and highest priority, including mid-scan.
- Reset values:
  - prescaler = 0, digit_sel = 0, shadow = 0, frame_done = 0.
  - an all inactive (4'b1111 when AN_ACTIVE_LOW=1).
  - seg blank (7'b1111111 when SEG_ACTIVE_LOW=1).
  - dp inactive.
- Prescaler: width $clog2(REFRESH_DIV). Counts 0..REFRESH_DIV-1, then wraps to 0.
- Slot advance: at terminal count, digit_sel advances 0→1→2→3→0. The 3→0 transition sets frame_done high for exactly one cycle.
- Shadow capture: on load=1 the shadow register captures all four inputs at that edge. Digit inputs are ignored when load=0.
- Load at slot boundary: if load and the prescaler terminal count coincide, both take effect. The new slot displays the new shadow value.
- Decode (active-high, before polarity inversion):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any value 10..15 decodes to 79 ("E").
  - Blank = 00.
- Leading-zero blanking, when blank_lz=1:
  - thousands is blanked if it is 0.
  - hundreds is blanked if thousands and hundreds are both 0.
  - tens is blanked if the upper three digits are all 0.
  - ones is never blanked.
  - A blanked digit drives its anode inactive for the whole slot.
  - An invalid digit (10..15) counts as nonzero and is never blanked.
- Anode timing: while prescaler < BLANK_CYC, all anodes are inactive. Otherwise only an[digit_sel] is active.
- Output registers: seg, an, and dp are registered. They reflect the prescaler, digit_sel, and shadow values of the previous cycle, giving 1-cycle latency. digit_sel and frame_done come directly from state registers.
- No combinational path exists from any input to any output.

Optional Feature:
- Macro: DISP_DP_EN.
- Defined:
  - Adds input dp_mask [3:0] and output dp [1].
  - dp_mask is captured into the shadow register together with the digits on load.
  - dp is active during slot k's active window iff shadow dp_mask[k]=1.
  - dp follows SEG_ACTIVE_LOW polarity, the same 1-cycle latency as seg, and the same guard interval.
- Undefined: ports dp_mask and dp do not exist, and no dp register is synthesised.

Test Plan:
All scenarios use REFRESH_DIV=4, BLANK_CYC=1, SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1.
1. Reset: assert reset for 3 cycles → an=4'b1111, seg=7'b1111111, digit_sel=0, frame_done=0. Release reset → digit_sel advances every 4 cycles; frame_done pulses once every 16 cycles.
2. Normal display: load with thousands=1, hundreds=2, tens=3, ones=4 → slot 0: an=4'b1111 for 1 cycle, then 4'b1110 with seg=~7'h66 for 3 cycles. Slot 3: an=4'b0111, seg=~7'h06.
3. Leading-zero blanking: load 0,0,0,7 with blank_lz=1 → an stays 4'b1111 throughout slots 1–3; slot 0 shows seg=~7'h07. With blank_lz=0 → slots 1–3 show seg=~7'h3F.
4. Invalid digit and load gating:
   - load hundreds=4'hC → slot 2 seg=~7'h79, an=4'b1011.
   - Change all inputs with load=0 → display unchanged for 2 full frames.
5. Boundaries:
   - load 9,9,9,9 on the same cycle as a slot-1 terminal count → slot 2 immediately shows ~7'h6F.
   - Assert reset mid-slot 2 → next cycle shows the reset values, frame_done stays 0, and shadow reads 0 after release.
6. DISP_DP_EN: load with dp_mask=4'b0100 → dp=0 (active) only in slot 2's active cycles, 1 otherwise. Build without the macro → compiles and passes tests 1–5.
